// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: opcodes, NOP encoding, immediate formats
// and the multi-cycle controller state type.
package rv_core_pkg;

   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } ctrl_state_t;

   // Encoding formats known to the immediate generator; only I and U are
   // produced by the current decoder.
   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   function automatic logic is_supported(input logic [6:0] opc);
      return (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
             (opc == OPC_LUI)    || (opc == OPC_AUIPC);
   endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator, selected by instruction format.
module rv_imm_gen
   import rv_core_pkg::*;
(
   input  logic [31:0] ir,
   input  imm_fmt_t    fmt,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'h0;
      case (fmt)
         IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
         IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_U:   imm = {ir[31:12], 12'h000};
         IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for RV32I OP-IMM, OP, LUI, AUIPC.
// Optional retired-instruction counter enabled by MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [6:0]  opcode_o,
   output logic [31:0] imm_o,
   output logic [31:0] pc_o,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [2:0]  alu_funct3,
   output logic        alu_alt,
   input  logic [31:0] alu_res,
   output logic        rf_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rf_wdata,
   output logic        illegal
`ifdef MULTICYCLE_CTRL_INSTRET_EN
   ,output logic [31:0] instret
`endif
);

   ctrl_state_t state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] wb_q, wb_d;
   logic        illegal_q, illegal_d;
   imm_fmt_t    imm_fmt;
   logic [6:0]  opc;
   logic [2:0]  funct3;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
   logic [31:0] instret_q, instret_d;
`endif

   assign opc    = ir_q[6:0];
   assign funct3 = ir_q[14:12];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= NOP_INSTR;
         wb_q      <= 32'h0;
         illegal_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
         instret_q <= 32'h0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         wb_q      <= wb_d;
         illegal_q <= illegal_d;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
         instret_q <= instret_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      wb_d      = wb_q;
      illegal_d = illegal_q;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
      instret_d = instret_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_supported(opc)) begin
               state_d = ST_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end
         end
         ST_EXEC: begin
            wb_d    = alu_res;
            state_d = ST_WB;
         end
         ST_WB: begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_FETCH;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
            instret_d = instret_q + 32'd1;
`endif
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      imm_fmt = IMM_NONE;
      case (opc)
         OPC_OP_IMM:         imm_fmt = IMM_I;
         OPC_LUI, OPC_AUIPC: imm_fmt = IMM_U;
         default:            imm_fmt = IMM_NONE;
      endcase
   end

   rv_imm_gen u_imm_gen (
      .ir  (ir_q),
      .fmt (imm_fmt),
      .imm (imm_o)
   );

   // LUI/AUIPC reuse the adder; only SRAI among immediates honours ir[30].
   always_comb begin
      alu_funct3 = 3'b000;
      alu_alt    = 1'b0;
      if (opc == OPC_OP) begin
         alu_funct3 = funct3;
         alu_alt    = ir_q[30];
      end else if (opc == OPC_OP_IMM) begin
         alu_funct3 = funct3;
         alu_alt    = (funct3 == 3'b101) ? ir_q[30] : 1'b0;
      end
   end

   assign imem_req  = (state_q == ST_FETCH) && !rst;
   assign imem_addr = pc_q;
   assign pc_o      = pc_q;
   assign opcode_o  = opc;
   assign rs1_addr  = ir_q[19:15];
   assign rs2_addr  = ir_q[24:20];
   assign rd_addr   = ir_q[11:7];
   assign rf_we     = (state_q == ST_WB) && (ir_q[11:7] != 5'd0) && !rst;
   assign rf_wdata  = wb_q;
   assign illegal   = illegal_q;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
   assign instret   = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a cycle-phase model checks every cycle,
// and a vector table pins the decode and write-back results with literals.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [6:0]  opcode_o;
   logic [31:0] imm_o;
   logic [31:0] pc_o;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [2:0]  alu_funct3;
   logic        alu_alt;
   logic [31:0] alu_res;
   logic        rf_we;
   logic [4:0]  rd_addr;
   logic [31:0] rf_wdata;
   logic        illegal;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
   logic [31:0] instret;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .opcode_o   (opcode_o),
      .imm_o      (imm_o),
      .pc_o       (pc_o),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .alu_funct3 (alu_funct3),
      .alu_alt    (alu_alt),
      .alu_res    (alu_res),
      .rf_we      (rf_we),
      .rd_addr    (rd_addr),
      .rf_wdata   (rf_wdata),
      .illegal    (illegal)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
      ,.instret   (instret)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Decode rules stated directly from the ISA subset.
   function automatic logic [31:0] f_imm(input logic [31:0] ir);
      case (ir[6:0])
         7'b0010011:             return {{20{ir[31]}}, ir[31:20]};
         7'b0110111, 7'b0010111: return {ir[31:12], 12'h000};
         default:                return 32'h0;
      endcase
   endfunction

   function automatic logic [2:0] f_f3(input logic [31:0] ir);
      if (ir[6:0] == 7'b0110011 || ir[6:0] == 7'b0010011) return ir[14:12];
      return 3'b000;
   endfunction

   function automatic logic f_alt(input logic [31:0] ir);
      if (ir[6:0] == 7'b0110011) return ir[30];
      if (ir[6:0] == 7'b0010011 && ir[14:12] == 3'b101) return ir[30];
      return 1'b0;
   endfunction

   // Model: phase counts edges since the instruction was accepted (-1 = fetching).
   bit          m_valid = 0;
   int          m_phase;
   bit          m_halt, m_illegal;
   logic [31:0] m_pc, m_ir, m_wb, m_instret;

   initial begin
      logic        s_rst, s_ack, exp_we, exp_req;
      logic [31:0] s_rdata, s_alu;
      forever begin
         @(posedge clk);
         s_rst = rst; s_ack = imem_ack; s_rdata = imem_rdata; s_alu = alu_res;
         if (s_rst) begin
            m_valid = 1; m_phase = -1; m_halt = 0; m_illegal = 0;
            m_pc = 32'h0; m_ir = 32'h0000_0013; m_wb = 32'h0; m_instret = 32'h0;
         end else if (m_valid && !m_halt) begin
            if (m_phase == -1) begin
               if (s_ack) begin m_ir = s_rdata; m_phase = 1; end
            end else if (m_phase == 1) begin
               if (m_ir[6:0] inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111})
                  m_phase = 2;
               else begin m_illegal = 1; m_halt = 1; m_phase = -1; end
            end else if (m_phase == 2) begin
               m_wb = s_alu; m_phase = 3;
            end else begin
               m_pc = m_pc + 32'd4; m_instret = m_instret + 32'd1; m_phase = -1;
            end
         end
         @(negedge clk);
         if (m_valid) begin
            exp_req = !rst && !m_halt && (m_phase == -1);
            exp_we  = !rst && (m_phase == 3) && (m_ir[11:7] != 5'd0);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_o", pc_o, m_pc);
            chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
            chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
            chk("opcode_o", {25'd0, opcode_o}, {25'd0, m_ir[6:0]});
            chk("imm_o", imm_o, f_imm(m_ir));
            chk("alu_funct3", {29'd0, alu_funct3}, {29'd0, f_f3(m_ir)});
            chk("alu_alt", {31'd0, alu_alt}, {31'd0, f_alt(m_ir)});
            chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, m_ir[19:15]});
            chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, m_ir[24:20]});
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_ir[11:7]});
            if (exp_we) chk("rf_wdata", rf_wdata, m_wb);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
            chk("instret", instret, m_instret);
`endif
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 alu_res = $urandom;
      end
   end

   // kind: 0 normal, 1 illegal then reset, 2 reset during EXEC, 3 reset during fetch wait
   typedef struct {
      logic [31:0] instr;
      int          delay;
      int          kind;
      bit          stray;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic        alt;
      logic        we;
      logic [4:0]  rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [31:0] instr, input int delay, input int kind, input bit stray,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                      input logic alt, input logic we, input logic [4:0] rd);
      vec_t v;
      v.instr = instr; v.delay = delay; v.kind = kind; v.stray = stray; v.pc = pc;
      v.imm = imm; v.f3 = f3; v.alt = alt; v.we = we; v.rd = rd;
      vecs.push_back(v);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; alu_res = 32'h0;
      add(32'h0050_0093, 0, 0, 0, 32'd0,  32'h0000_0005, 3'd0, 1'b0, 1'b1, 5'd1);
      add(32'h1234_5137, 1, 0, 0, 32'd4,  32'h1234_5000, 3'd0, 1'b0, 1'b1, 5'd2);
      add(32'h0000_1197, 3, 0, 0, 32'd8,  32'h0000_1000, 3'd0, 1'b0, 1'b1, 5'd3);
      add(32'h4022_D293, 0, 0, 1, 32'd12, 32'h0000_0402, 3'd5, 1'b1, 1'b1, 5'd5);
      add(32'h40B5_0533, 1, 0, 0, 32'd16, 32'h0000_0000, 3'd0, 1'b1, 1'b1, 5'd10);
      add(32'h0020_8033, 2, 0, 1, 32'd20, 32'h0000_0000, 3'd0, 1'b0, 1'b0, 5'd0);
      add(32'hFFF0_0093, 0, 0, 0, 32'd24, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b1, 5'd1);
      add(32'h4000_0093, 0, 0, 0, 32'd28, 32'h0000_0400, 3'd0, 1'b0, 1'b1, 5'd1);
      add(32'h0000_0000, 1, 1, 0, 32'd32, 32'h0000_0000, 3'd0, 1'b0, 1'b0, 5'd0);
      add(32'h0050_0093, 0, 3, 0, 32'd0,  32'h0000_0005, 3'd0, 1'b0, 1'b1, 5'd1);
      add(32'h0050_0093, 0, 2, 0, 32'd0,  32'h0000_0005, 3'd0, 1'b0, 1'b1, 5'd1);
      add(32'h0000_1197, 1, 0, 0, 32'd0,  32'h0000_1000, 3'd0, 1'b0, 1'b1, 5'd3);
      add(32'h00A0_0113, 0, 0, 0, 32'd4,  32'h0000_000A, 3'd0, 1'b0, 1'b1, 5'd2);

      step(); step();
      @(negedge clk);
      chk("reset_req_low", {31'd0, imem_req}, 32'd0);
      chk("reset_we_low", {31'd0, rf_we}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_pc", pc_o, 32'h0);
      chk("post_reset_addr", imem_addr, 32'h0);
      chk("post_reset_req", {31'd0, imem_req}, 32'd1);
      chk("post_reset_illegal", {31'd0, illegal}, 32'd0);

      foreach (vecs[i]) begin
         vec_t v;
         int   k;
         v = vecs[i];
         k = 0;
         while (!imem_req && k < 50) begin step(); k++; end
         chk("req_seen", {31'd0, imem_req}, 32'd1);
         chk("fetch_addr", imem_addr, v.pc);
         if (v.kind == 3) begin
            step(); step();
            pulse_reset();
            @(negedge clk);
            chk("abandon_req", {31'd0, imem_req}, 32'd1);
            chk("abandon_pc", pc_o, 32'h0);
            $display("vec %0d instr=%h fetch abandoned by reset", i, v.instr);
            continue;
         end
         for (int d = 0; d < v.delay; d++) begin
            step();
            chk("wait_addr_stable", imem_addr, v.pc);
         end
         imem_ack = 1'b1; imem_rdata = v.instr;
         step();
         imem_ack = v.stray; imem_rdata = $urandom;
         @(negedge clk);
         chk("dec_opcode", {25'd0, opcode_o}, {25'd0, v.instr[6:0]});
         chk("dec_imm", imm_o, v.imm);
         chk("dec_funct3", {29'd0, alu_funct3}, {29'd0, v.f3});
         chk("dec_alt", {31'd0, alu_alt}, {31'd0, v.alt});
         step();
         imem_ack = 1'b0;
         if (v.kind == 1) begin
            for (int h = 0; h < 5; h++) begin
               @(negedge clk);
               chk("halt_req", {31'd0, imem_req}, 32'd0);
               chk("halt_illegal", {31'd0, illegal}, 32'd1);
               chk("halt_we", {31'd0, rf_we}, 32'd0);
               step();
            end
            pulse_reset();
            @(negedge clk);
            chk("unhalt_pc", pc_o, 32'h0);
            chk("unhalt_illegal", {31'd0, illegal}, 32'd0);
            chk("unhalt_req", {31'd0, imem_req}, 32'd1);
            $display("vec %0d instr=%h illegal, halted, reset", i, v.instr);
            continue;
         end
         if (v.kind == 2) begin
            rst = 1'b1;
            @(negedge clk);
            chk("exec_rst_we", {31'd0, rf_we}, 32'd0);
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("exec_rst_we_after", {31'd0, rf_we}, 32'd0);
            chk("exec_rst_pc", pc_o, 32'h0);
            $display("vec %0d instr=%h reset during EXEC", i, v.instr);
            continue;
         end
         step();
         @(negedge clk);
         chk("wb_we", {31'd0, rf_we}, {31'd0, v.we});
         if (v.we) chk("wb_rd", {27'd0, rd_addr}, {27'd0, v.rd});
         step();
         @(negedge clk);
         chk("next_pc", pc_o, v.pc + 32'd4);
         $display("vec %0d instr=%h pc=%h we=%0d rd=%0d", i, v.instr, v.pc, v.we, v.rd);
      end

      step(); step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passes, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I integer core subset: OP-IMM, OP, LUI, AUIPC.
- Fetches instructions over a req/ack instruction-memory port, decodes them and generates immediates.
- Drives the operand builder (opcode, imm, pc) and ALU control, then writes the latched ALU result back to the register file.
- Sits between the instruction memory, the register file and the operand-builder/ALU datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- opcode_o  out  7  ir[6:0], to the operand builder's opcode select
- imm_o  out  32  generated immediate, to the operand builder
- pc_o  out  32  current pc, to the operand builder
- rs1_addr  out  5  ir[19:15]
- rs2_addr  out  5  ir[24:20]
- alu_funct3  out  3  ALU operation select
- alu_alt  out  1  SUB/SRA select
- alu_res  in  32  ALU result
- rf_we  out  1  register-file write enable
- rd_addr  out  5  ir[11:7]
- rf_wdata  out  32  latched write-back data
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst high at an edge):
  - state=FETCH, pc=RESET_PC, ir=32'h0000_0013 (NOP), wb_q=0, illegal=0.
  - While rst is high: imem_req=0 and rf_we=0.
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - imem_req=1 combinationally, imem_addr=pc.
  - imem_ack is sampled each cycle; on ack, ir<=imem_rdata and go to DECODE, otherwise stay.
  - Same-cycle ack is legal.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - If opcode is not one of {0010011, 0110011, 0110111, 0010111}: illegal<=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - Operands are valid at the operand builder and ALU.
  - wb_q<=alu_res; go to WB.
- WB:
  - rf_we=1 for exactly this cycle, with rd_addr and rf_wdata=wb_q.
  - rf_we is forced 0 when rd==0.
  - pc<=pc+4, wrapping modulo 2^32; go to FETCH.
- HALT:
  - Terminal until rst; imem_req=0, rf_we=0.
- CPI = 4 + fetch wait cycles.
- Immediate generation (combinational from ir):
  - OP-IMM: sign-extended ir[31:20].
  - LUI and AUIPC: {ir[31:12], 12'b0}.
  - OP and illegal: 0.
- ALU control:
  - alu_funct3 = ir[14:12] for OP and OP-IMM; forced 3'b000 (add) for LUI and AUIPC.
  - alu_alt = ir[30] for OP, and for OP-IMM only when funct3==101; otherwise 0.
- opcode_o, imm_o, rs1/rs2/rd addresses and ALU control are driven from ir in every state; consumers use them only in EXEC/WB.
- Reset mid-operation, including during an outstanding fetch: request is abandoned; no write-back occurs at or after that edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTRET_EN.
- When defined:
  - Adds output instret [31:0], reset to 0.
  - Increments by 1 on each WB cycle, including rd==0; wraps at 2^32.
  - Not incremented on illegal instructions.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package rv_core_pkg holds:
  - opcode constants OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC;
  - NOP constant 32'h0000_0013;
  - ctrl_state_t enum.
- Sub-module: rv_imm_gen, a combinational immediate generator from ir. It is reusable by later load/store/branch extensions.

Test Plan:
- Reset with RESET_PC=0 → pc_o=0, imem_addr=0, imem_req=1 once rst drops, rf_we=0, illegal=0.
- ADDI x1,x0,5 (0x00500093), ack same cycle as req → opcode_o=0010011, imm_o=5, alu_funct3=000; rf_we=1 exactly 3 cycles after the ack cycle, rd_addr=1, rf_wdata=alu_res; pc_o then 4.
- LUI x2,0x12345 (0x12345137) → imm_o=32'h1234_5000, alu_funct3=000, alu_alt=0; AUIPC 0x00001197 → imm_o=32'h0000_1000, rd=3.
- Fetch with ack delayed 3 cycles → imem_req held 4 cycles, imem_addr stable, no rf_we.
- SRAI x5,x5,2 (0x4022D293) → alu_alt=1, funct3=101; SUB 0x40B50533 → alu_alt=1; ADD x0,x1,x2 (0x00208033) → rf_we stays 0, pc advances by 4.
- Instruction 0x00000000 → illegal=1, state HALT, imem_req=0 thereafter, no rf_we; rst pulse → FETCH at RESET_PC, illegal=0.
